corr_result_packer: RTL and testbench

//  Downstream of the correlator core. On a start pulse, snapshots the status word and the six
//  64-bit accumulators and serialises them as a framed, checksummed byte packet.

---
 rtl/corr_result_packer_pkg.sv | 25 ++
 rtl/corr_result_packer_byte_shift_reg.sv | 28 ++
 rtl/corr_result_packer.sv | 146 ++++++++++++++
 tb/tb_corr_result_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/corr_result_packer_pkg.sv
// Shared constants and FSM encoding for the correlator result packer.
// The state encodings are fixed so that debug logic elsewhere can decode them.
package corr_result_packer_pkg;

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;
  localparam int         DEFAULT_SR_W     = 32;
  localparam int         DEFAULT_SUM_W    = 64;
  localparam int         NUM_SUMS         = 6;

  function automatic int payload_bytes(input int sr_w, input int sum_w);
    return sr_w / 8 + NUM_SUMS * sum_w / 8;
  endfunction

  localparam int PKT_PAYLOAD_BYTES = payload_bytes(DEFAULT_SR_W, DEFAULT_SUM_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HDR   = 3'd2,
    ST_DATA  = 3'd3,
    ST_CKSUM = 3'd4,
    ST_DONE  = 3'd5
  } pkt_state_e;

endpackage

// File: rtl/corr_result_packer_byte_shift_reg.sv
// Snapshot register for the packer: parallel load, shift left by one byte,
// with the most significant byte always presented on top_o.
module corr_result_packer_byte_shift_reg #(
  parameter int WIDTH = 416
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [7:0]       top_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[WIDTH-9:0], 8'h00};
    end
  end

  assign top_o = data_q[WIDTH-1 -: 8];

endmodule

// File: rtl/corr_result_packer.sv
// Snapshots the correlator status word and six accumulators on start and
// streams them as HDR | payload | checksum bytes over a valid/ready link.
module corr_result_packer
  import corr_result_packer_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE,
  parameter int         SR_W     = DEFAULT_SR_W,
  parameter int         SUM_W    = DEFAULT_SUM_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [SR_W-1:0]  sr_in,
  input  logic [SUM_W-1:0] sum_x_2,
  input  logic [SUM_W-1:0] sum_y_2,
  input  logic [SUM_W-1:0] sum_xy,
  input  logic [SUM_W-1:0] sum_xy90,
  input  logic [SUM_W-1:0] sum_y90_2,
  input  logic [SUM_W-1:0] sum_y_y90,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             busy,
  output logic             pkt_done
);

  localparam int PAYLOAD = payload_bytes(SR_W, SUM_W);
  localparam int SNAP_W  = PAYLOAD * 8;
  localparam int CNT_W   = $clog2(PAYLOAD + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD - 1);

  pkt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             pkt_done_q, pkt_done_d;

  logic             snap_load, snap_shift, xfer;
  logic [7:0]       snap_top;
  logic [SNAP_W-1:0] snap_data;

  assign snap_data = {sr_in, sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90};
  assign xfer      = tx_valid_q && tx_ready;

  corr_result_packer_byte_shift_reg #(
    .WIDTH(SNAP_W)
  ) u_snap (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .load_i (snap_load),
    .shift_i(snap_shift),
    .data_i (snap_data),
    .top_o  (snap_top)
  );

  // The shift register always holds the next byte to present on its top, so
  // every accepted byte shifts and reloads tx_data from the new top.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cksum_d    = cksum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pkt_done_d = 1'b0;
    snap_load  = 1'b0;
    snap_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        snap_load  = 1'b1;
        cksum_d    = '0;
        cnt_d      = '0;
        tx_data_d  = HDR_BYTE;
        tx_valid_d = 1'b1;
        state_d    = ST_HDR;
      end
      ST_HDR: begin
        if (xfer) begin
          tx_data_d  = snap_top;
          snap_shift = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          cksum_d    = cksum_q + tx_data_q;
          cnt_d      = cnt_q + CNT_W'(1);
          snap_shift = 1'b1;
          if (cnt_q == LAST_IDX) begin
            tx_data_d = cksum_q + tx_data_q;
            state_d   = ST_CKSUM;
          end else begin
            tx_data_d = snap_top;
          end
        end
      end
      ST_CKSUM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          pkt_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cksum_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cksum_q    <= cksum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_corr_result_packer.sv
// Directed and randomized bench for corr_result_packer; the expected packet is
// rebuilt from the input values with plain arithmetic on every start.
module tb_corr_result_packer;
  import corr_result_packer_pkg::*;

  localparam int NBYTES = PKT_PAYLOAD_BYTES + 2;
  localparam int LIMIT  = 2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, tx_ready;
  logic [31:0] sr_in;
  logic [63:0] sums [6];
  logic [7:0]  tx_data;
  logic        tx_valid, busy, pkt_done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q [$];

  int          nBytes, doneCycle;
  logic [7:0]  lastByte;
  bit          sawValid, sawDone;

  corr_result_packer dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .sr_in    (sr_in),
    .sum_x_2  (sums[0]),
    .sum_y_2  (sums[1]),
    .sum_xy   (sums[2]),
    .sum_xy90 (sums[3]),
    .sum_y90_2(sums[4]),
    .sum_y_y90(sums[5]),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Packet as a byte list: header, status MSB-first, sums MSB-first, checksum.
  function automatic void buildExpected();
    logic [7:0] b;
    int total;
    total = 0;
    exp_q.delete();
    exp_q.push_back(DEFAULT_HDR_BYTE);
    for (int i = 0; i < 4; i++) begin
      b = 8'(sr_in >> (8 * (3 - i)));
      exp_q.push_back(b);
      total += int'(b);
    end
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 8; i++) begin
        b = 8'(sums[s] >> (8 * (7 - i)));
        exp_q.push_back(b);
        total += int'(b);
      end
    end
    exp_q.push_back(8'(total % 256));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomInputs();
    sr_in = $urandom;
    for (int s = 0; s < 6; s++) sums[s] = {$urandom, $urandom};
  endtask

  task automatic watchIdle(input int n, output bit v, output bit d);
    v = 1'b0;
    d = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (tx_valid) v = 1'b1;
      if (pkt_done) d = 1'b1;
    end
  endtask

  // Pulses start, then consumes the packet byte by byte against exp_q.
  task automatic applyStimulus(input bit randReady, input bit mutate, input bit extraStarts,
                               input int abortAt, output int nb, output int dc,
                               output logic [7:0] lb);
    int cyc;
    int idx;
    bit rdy;
    bit holdPending;
    bit finished;
    logic [7:0] heldData;
    cyc = 0;
    idx = 0;
    holdPending = 1'b0;
    finished = 1'b0;
    heldData = '0;
    dc = -1;
    lb = '0;
    buildExpected();
    @(negedge sys_clk);
    start = 1'b1;
    tx_ready = 1'b0;
    while (!finished) begin
      @(negedge sys_clk);
      cyc++;
      start = 1'b0;
      if (cyc == 2) checkOutput("hdr_latency", 64'({tx_valid, tx_data}), 64'({1'b1, DEFAULT_HDR_BYTE}));
      if (holdPending) begin
        checkOutput("hold_valid", 64'(tx_valid), 64'(1));
        checkOutput("hold_data", 64'(tx_data), 64'(heldData));
      end
      holdPending = 1'b0;
      if (mutate && cyc == 3) randomInputs();
      if (pkt_done) begin
        dc = cyc;
        checkOutput("busy_on_done", 64'(busy), 64'(1));
        if (extraStarts) start = 1'b1;
        finished = 1'b1;
      end else if (abortAt >= 0 && idx == abortAt && tx_valid) begin
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checkOutput("abort_valid", 64'(tx_valid), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(pkt_done), 64'(0));
        finished = 1'b1;
      end else if (cyc >= LIMIT) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL timeout observed=%0d cycles required=pkt_done", cyc);
        finished = 1'b1;
      end else begin
        rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_ready = rdy;
        if (extraStarts && tx_valid && rdy && (idx == 10 || idx == 53)) start = 1'b1;
        if (tx_valid && rdy) begin
          if (idx < NBYTES) checkOutput($sformatf("byte%0d", idx), 64'(tx_data), 64'(exp_q[idx]));
          else checkOutput("byte_overrun", 64'(idx), 64'(NBYTES - 1));
          lb = tx_data;
          idx++;
        end else if (tx_valid) begin
          holdPending = 1'b1;
          heldData = tx_data;
        end
      end
    end
    nb = idx;
    if (abortAt < 0) begin
      @(negedge sys_clk);
      start = 1'b0;
      tx_ready = 1'b0;
      checkOutput("post_busy", 64'(busy), 64'(0));
      checkOutput("post_done", 64'(pkt_done), 64'(0));
      checkOutput("post_valid", 64'(tx_valid), 64'(0));
    end
  endtask

  task automatic setTest1Inputs();
    sr_in = 32'h0000_0001;
    for (int s = 0; s < 6; s++) sums[s] = 64'h0;
    sums[0] = 64'h0102_0304_0506_0708;
  endtask

  initial begin
    sys_rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b0;
    sr_in = '0;
    for (int s = 0; s < 6; s++) sums[s] = '0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_tx_data", 64'(tx_data), 64'(0));
    checkOutput("rst_tx_valid", 64'(tx_valid), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_pkt_done", 64'(pkt_done), 64'(0));
    sys_rst = 1'b0;
    @(negedge sys_clk);

    setTest1Inputs();
    applyStimulus(1'b0, 1'b0, 1'b0, -1, nBytes, doneCycle, lastByte);
    checkOutput("t1_bytes", 64'(nBytes), 64'(54));
    checkOutput("t1_done_cycle", 64'(doneCycle), 64'(56));
    checkOutput("t1_cksum", 64'(lastByte), 64'(8'h25));

    sr_in = '1;
    for (int s = 0; s < 6; s++) sums[s] = '1;
    applyStimulus(1'b0, 1'b0, 1'b0, -1, nBytes, doneCycle, lastByte);
    checkOutput("t2_bytes", 64'(nBytes), 64'(54));
    checkOutput("t2_done_cycle", 64'(doneCycle), 64'(56));
    checkOutput("t2_cksum", 64'(lastByte), 64'(8'hCC));

    setTest1Inputs();
    applyStimulus(1'b1, 1'b0, 1'b0, -1, nBytes, doneCycle, lastByte);
    checkOutput("t3_bytes", 64'(nBytes), 64'(54));
    checkOutput("t3_cksum", 64'(lastByte), 64'(8'h25));

    randomInputs();
    applyStimulus(1'b0, 1'b1, 1'b0, -1, nBytes, doneCycle, lastByte);
    checkOutput("t4_bytes", 64'(nBytes), 64'(54));

    randomInputs();
    applyStimulus(1'b0, 1'b0, 1'b1, -1, nBytes, doneCycle, lastByte);
    checkOutput("t5_bytes", 64'(nBytes), 64'(54));
    watchIdle(80, sawValid, sawDone);
    checkOutput("t5_no_second_pkt", 64'(sawValid), 64'(0));
    checkOutput("t5_no_second_done", 64'(sawDone), 64'(0));

    randomInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 20, nBytes, doneCycle, lastByte);
    checkOutput("t6_abort_at", 64'(nBytes), 64'(20));
    watchIdle(60, sawValid, sawDone);
    checkOutput("t6_no_done", 64'(sawDone), 64'(0));
    checkOutput("t6_no_valid", 64'(sawValid), 64'(0));
    randomInputs();
    applyStimulus(1'b1, 1'b0, 1'b0, -1, nBytes, doneCycle, lastByte);
    checkOutput("t6_resume_bytes", 64'(nBytes), 64'(54));

    for (int k = 0; k < 3; k++) begin
      randomInputs();
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, -1, nBytes, doneCycle, lastByte);
      checkOutput("rand_bytes", 64'(nBytes), 64'(54));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
